serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised, multi-cycle successor to the single-bit full adder. Adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first, using a valid/ready handshake on both sides. Used in the datapath where area matters more than latency. Reports sum, carry-out and signed overflow. Subtraction is a compile-time option.

## Interface
- WIDTH, 32: operand and result width in bits; ≥ 2.
- DIGIT, 1: bits processed per cycle. WIDTH % DIGIT == 0 is required; an elaboration-time assertion enforces it.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode)
- sub  input  1  1 = compute a − b. Honoured only with SERIAL_ADDER_SUB_EN.
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; in subtract mode, 1 = no borrow
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- NDIG = WIDTH/DIGIT. Three-state FSM: IDLE, RUN, DONE.
- IDLE
  - in_ready = 1.
  - When in_valid && in_ready: capture a, b, cin and sub into shift registers, clear the digit counter, go to RUN.
- RUN
  - Each cycle, add the low DIGIT bits of the A and B registers plus the carry register.
  - Shift the result digit into sum from the MSB end. Shift the operands right by DIGIT and update the carry.
  - After the cycle that processes digit NDIG−1: latch cout and ovf, go to DONE.
  - in_ready = 0. in_valid is ignored.
- DONE
  - out_valid = 1; sum, cout and ovf are held stable.
  - When out_ready is high: go to IDLE.
  - Operands cannot be accepted in the same cycle as the result is consumed.
- Subtract (macro enabled, sub = 1): the B register is loaded with ~b, the initial carry is 1, and cin is ignored.
- Arithmetic is modulo 2^WIDTH. ovf is computed from the carry into and out of bit WIDTH−1.
- Reset (asynchronous, any state):
  - State goes to IDLE; the counter, carry and shift registers clear.
  - Outputs go to sum = 0, cout = 0, ovf = 0, out_valid = 0, in_ready = 1.
  - A reset during RUN discards the operation, and no result is produced.

## Timing
- Operands are accepted on edge T. out_valid rises after edge T+NDIG. Latency is NDIG cycles.
- Minimum issue interval is NDIG+2 cycles: the accept edge, NDIG RUN cycles, then the DONE handshake.
- in_ready and out_valid are decoded from state registers only, so there is no combinational path from in_valid or out_ready.
- sum, cout and ovf are registered. They change only at the final RUN edge and at reset.
- in_valid may be held across an accept. A second transfer needs a new IDLE cycle.

## Configuration
- SERIAL_ADDER_SUB_EN
  - Defined: sub selects subtraction as described above.
  - Undefined: sub is ignored (always add) and the inversion mux is not built.

## Structure
- Shared package serial_adder_pkg holds:
  - state_e typedef (IDLE, RUN, DONE);
  - helper function clog2-based COUNT_W(NDIG).
- One sub-module, digit_adder: combinational DIGIT-bit ripple adder that chains the existing full_adder cell and exports the carry into its MSB for overflow.
- The top level holds the FSM, counter, shift registers and handshake.

## Test plan
- WIDTH=8, DIGIT=1, a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. out_valid rises 8 cycles after accept.
- WIDTH=8, DIGIT=1, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Repeat with cin=1 → sum=0x01, cout=1.
- SERIAL_ADDER_SUB_EN, WIDTH=8, sub=1:
  - a=0x05, b=0x07 → sum=0xFE, cout=0, ovf=0;
  - a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
- WIDTH=8, DIGIT=4, a=0x3C, b=0x0F → sum=0x4B, cout=0. Latency is 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum, cout, ovf and out_valid stable and in_ready=0. Raising out_ready returns the FSM to IDLE on the next edge.
- Assert rst_n low at RUN digit 3 of 8 → same cycle: out_valid=0, in_ready=1, sum=0. After release, a fresh 0x01+0x01 → 0x02 with normal latency.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Width of the digit counter; at least one bit even for a single-digit build.
  function automatic int count_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Full-adder cell and the DIGIT-bit ripple adder built from it.
// o_cmsb is the carry entering the top bit of the digit, used for signed overflow.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);
  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    full_adder u_fa (
      .i_a (i_a[g]),
      .i_b (i_b[g]),
      .i_c (w_c[g]),
      .o_s (o_sum[g]),
      .o_c (w_c[g+1])
    );
  end

  assign o_cout = w_c[DIGIT];
  assign o_cmsb = w_c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Digit-serial WIDTH-bit adder, DIGIT bits per clock, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to let `sub` select a - b; otherwise `sub` is ignored.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = count_w(NDIG);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_dsum;
  logic             w_dcout;
  logic             w_dcmsb;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_load     = b;
  assign w_c_load     = cin;
`endif

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_dsum),
    .o_cout (w_dcout),
    .o_cmsb (w_dcmsb)
  );

  // New digit enters at the MSB end so the finished word lands in place after NDIG shifts.
  assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));
  assign w_last     = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_dcout;
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_dcout;
            r_ovf   <= w_dcout ^ w_dcmsb;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 with DIGIT=1 and DIGIT=4 instances.
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       d1_in_valid, d1_in_ready, d1_cin, d1_sub, d1_out_valid, d1_out_ready, d1_cout, d1_ovf;
  logic [7:0] d1_a, d1_b, d1_sum;
  logic       d4_in_valid, d4_in_ready, d4_cin, d4_sub, d4_out_valid, d4_out_ready, d4_cout, d4_ovf;
  logic [7:0] d4_a, d4_b, d4_sum;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .a(d1_a), .b(d1_b), .cin(d1_cin), .sub(d1_sub), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .sum(d1_sum), .cout(d1_cout), .ovf(d1_ovf));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .a(d4_a), .b(d4_b), .cin(d4_cin), .sub(d4_sub), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready), .sum(d4_sum), .cout(d4_cout), .ovf(d4_ovf));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } res_t;

  res_t q1[$];
  res_t q4[$];
  res_t e1, e4;
  vec_t tbl[14];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
    res_t       r;
    logic [7:0] bb;
    logic       c;
    logic [8:0] full;
    logic [7:0] low;
    bb = b;
    c  = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      bb = ~b;
      c  = 1'b1;
    end
`else
    if (sub) c = cin;
`endif
    full = {1'b0, a} + {1'b0, bb} + {8'd0, c};
    low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'd0, c};
    r.s  = full[7:0];
    r.co = full[8];
    r.ov = low[7] ^ full[8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && d1_out_valid && d1_out_ready) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL d1_unexpected: got result %0h, required none", d1_sum);
      end else begin
        e1 = q1.pop_front();
        chk("d1_sum", {24'd0, d1_sum}, {24'd0, e1.s});
        chk("d1_cout", {31'd0, d1_cout}, {31'd0, e1.co});
        chk("d1_ovf", {31'd0, d1_ovf}, {31'd0, e1.ov});
      end
    end
    if (rst_n && d4_out_valid && d4_out_ready) begin
      if (q4.size() == 0) begin
        n_total++;
        $display("FAIL d4_unexpected: got result %0h, required none", d4_sum);
      end else begin
        e4 = q4.pop_front();
        chk("d4_sum", {24'd0, d4_sum}, {24'd0, e4.s});
        chk("d4_cout", {31'd0, d4_cout}, {31'd0, e4.co});
        chk("d4_ovf", {31'd0, d4_ovf}, {31'd0, e4.ov});
      end
    end
  end

  task automatic start1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input bit push, input res_t exp);
    int w = 0;
    @(negedge clk);
    while (!d1_in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!d1_in_ready) begin
      n_total++;
      $display("FAIL d1_ready_timeout: in_ready got 0, required 1");
    end
    d1_a = a; d1_b = b; d1_cin = cin; d1_sub = sub; d1_in_valid = 1'b1;
    if (push) q1.push_back(exp);
    @(posedge clk);
    #1 d1_in_valid = 1'b0;
  endtask

  task automatic wait1(input int exp_lat, input string name);
    int lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (d1_out_valid) break;
    end
    chk(name, lat, exp_lat);
  endtask

  task automatic start4(input logic [7:0] a, input logic [7:0] b, input logic cin, input res_t exp);
    int w = 0;
    @(negedge clk);
    while (!d4_in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!d4_in_ready) begin
      n_total++;
      $display("FAIL d4_ready_timeout: in_ready got 0, required 1");
    end
    d4_a = a; d4_b = b; d4_cin = cin; d4_sub = 1'b0; d4_in_valid = 1'b1;
    q4.push_back(exp);
    @(posedge clk);
    #1 d4_in_valid = 1'b0;
  endtask

  task automatic wait4(input int exp_lat, input string name);
    int lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (d4_out_valid) break;
    end
    chk(name, lat, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    rst_n = 1'b0;
    d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_cin = 1'b0; d1_sub = 1'b0; d1_out_ready = 1'b1;
    d4_in_valid = 1'b0; d4_a = '0; d4_b = '0; d4_cin = 1'b0; d4_sub = 1'b0; d4_out_ready = 1'b1;

    tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
`ifdef SERIAL_ADDER_SUB_EN
    tbl[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
`else
    tbl[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
`endif
    for (int i = 6; i < 14; i++) begin
      tbl[i].a   = 8'($urandom);
      tbl[i].b   = 8'($urandom);
      tbl[i].cin = 1'($urandom_range(0, 1));
      tbl[i].sub = 1'($urandom_range(0, 1));
      r          = model(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      tbl[i].s   = r.s;
      tbl[i].co  = r.co;
      tbl[i].ov  = r.ov;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, d1_in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, d1_out_valid}, 32'd0);
    chk("rst_sum", {24'd0, d1_sum}, 32'd0);
    chk("rst_cout", {31'd0, d1_cout}, 32'd0);
    chk("rst_ovf", {31'd0, d1_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      r.s = tbl[i].s; r.co = tbl[i].co; r.ov = tbl[i].ov;
      start1(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1, r);
      wait1(8, "d1_latency");
    end

    r = '{8'h4B, 1'b0, 1'b0};
    start4(8'h3C, 8'h0F, 1'b0, r);
    wait4(2, "d4_latency");
    r = '{8'h11, 1'b1, 1'b0};
    start4(8'hF0, 8'h20, 1'b1, r);
    wait4(2, "d4_latency");
    r = '{8'h80, 1'b0, 1'b1};
    start4(8'h40, 8'h40, 1'b0, r);
    wait4(2, "d4_latency");

    // Backpressure: result must sit still while the consumer stalls.
    d1_out_ready = 1'b0;
    r = '{8'h80, 1'b0, 1'b1};
    start1(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, r);
    wait1(8, "bp_latency");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, d1_out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, d1_in_ready}, 32'd0);
      chk("bp_sum", {24'd0, d1_sum}, 32'h80);
      chk("bp_cout", {31'd0, d1_cout}, 32'd0);
      chk("bp_ovf", {31'd0, d1_ovf}, 32'd1);
    end
    d1_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", {31'd0, d1_out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, d1_in_ready}, 32'd1);

    // Reset in the middle of a run discards the operation.
    r = '{8'h00, 1'b0, 1'b0};
    start1(8'h55, 8'h22, 1'b0, 1'b0, 1'b0, r);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, d1_out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, d1_in_ready}, 32'd1);
    chk("midrst_sum", {24'd0, d1_sum}, 32'd0);
    chk("midrst_ovf", {31'd0, d1_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    r = '{8'h02, 1'b0, 1'b0};
    start1(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, r);
    wait1(8, "post_rst_latency");

    @(negedge clk);
    @(negedge clk);
    chk("d1_queue_drained", q1.size(), 32'd0);
    chk("d4_queue_drained", q4.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
